stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Run/pause/lap/clear controller for the stopwatch. It takes the debounced button levels, converts them into edge events and sequences the time-counter datapath. Its outputs are a count-enable tick, a clear pulse and a display-freeze (lap) flag. It sits between the per-button debouncers and the BCD time counters and display mux.

## Interface
- TICK_DVSR, 1_000_000: clk cycles per count tick (10 ms at 100 MHz); must be ≥ 2
- HOLD_TICKS, 100: count ticks clr_in must be held for a long-press clear; used only with the macro; must be ≥ 1

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- go_in  in  1  debounced start/stop button level
- lap_in  in  1  debounced lap button level
- clr_in  in  1  debounced clear button level
- tick_out  out  1  one-cycle count-enable pulse to the time counters
- clr_out  out  1  one-cycle synchronous clear pulse to the time counters
- lap_hold  out  1  1 = display shows the frozen lap value
- run  out  1  1 = counting (state RUN or LAP)
- state  out  2  current state: IDLE=00, RUN=01, PAUSE=10, LAP=11

## Operation
- **Edge detect.** One prev register per button. Event = in & ~prev.
  - prev registers reset to 1, so a button held through reset produces no event until it is released and pressed again.
- **Priority** within a cycle: clr > go > lap. Only the highest-priority valid event is acted on; the rest are dropped.
- **State machine** (Moore outputs):
  - IDLE: go → RUN, with the prescaler zeroed. clr → clr_out pulse, stay in IDLE. lap is ignored.
  - RUN: go → PAUSE. lap → LAP. clr is ignored (short press).
  - LAP: lap → RUN (releases the freeze). go → PAUSE (freeze dropped). Counting continues in LAP.
  - PAUSE: go → RUN. clr → clr_out pulse and go to IDLE. lap is ignored.
- **Outputs by state:**
  - run = 1 in RUN and LAP.
  - lap_hold = 1 in LAP only.
  - state = encoding above.
- **Prescaler.** Width $clog2(TICK_DVSR).
  - Increments while run = 1; holds its value in PAUSE.
  - Forced to 0 in IDLE.
  - At TICK_DVSR-1 it wraps to 0 and asserts tick_out the next cycle.
- **Phase across pause.** RUN→PAUSE→RUN preserves the prescaler value, so no partial tick is lost or duplicated.

## Timing
- **Reset values:** state IDLE, run 0, lap_hold 0, tick_out 0, clr_out 0, prescaler 0, hold counter 0, prev registers 1.
- **Event latency:** an event sampled at clock edge N changes state at edge N; run, lap_hold and state reflect it from cycle N+1.
- **clr_out** is registered: high for exactly one cycle, N+1.
- **First tick after IDLE→RUN:** tick_out is high exactly TICK_DVSR cycles after run first goes high, then every TICK_DVSR cycles while running.
- **Pause edge:** a tick due in the same cycle as a pause event is still emitted.
- **Mid-operation reset:** any rst assertion returns all registers to their reset values immediately. No clr_out pulse is generated.

## Configuration
- **LONG_PRESS_CLR_EN defined:**
  - A hold counter, width $clog2(HOLD_TICKS+1), counts tick_out pulses while clr_in = 1 in RUN or LAP. It is zeroed whenever clr_in = 0 or the state is IDLE/PAUSE.
  - When it reaches HOLD_TICKS: clr_out pulses, the state goes to IDLE and the counter zeroes.
  - This takes priority over a same-cycle go or lap event.
- **Not defined:** the hold counter is absent and clr_in is ignored in RUN and LAP.

## Test plan
Parameters for all scenarios: TICK_DVSR=10, HOLD_TICKS=3.
- Hold go_in=1 through reset release → no state change; release then press → state 01 one cycle after the press; first tick_out 10 cycles after run rises.
- RUN for 25 cycles, pause with go, wait 40 cycles, resume → the next tick_out arrives 5 cycles after resume (phase preserved); no tick_out during PAUSE.
- RUN, press lap → lap_hold=1, tick_out continues; press lap → lap_hold=0, state 01; press lap, then go → state 10, lap_hold=0.
- PAUSE, press clr and go in the same cycle → clr_out high for one cycle, state 00, run 0.
- RUN, hold clr_in for 35 cycles:
  - with LONG_PRESS_CLR_EN → clr_out pulses after the 3rd tick_out, state 00;
  - without it → state stays 01, no clr_out.
- Assert rst for 2 cycles mid-LAP → all outputs 0, state 00, no clr_out; the next go press starts from a prescaler value of 0.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller button/datapath bundle.
//   master : side that drives the debounced buttons and consumes the controls
//   slave  : the controller (stopwatch_ctrl)
// Signals:
//   go_in, lap_in, clr_in : debounced button levels
//   tick_out              : one-cycle count-enable pulse
//   clr_out               : one-cycle synchronous clear pulse
//   lap_hold              : display frozen on lap value
//   run                   : counting (RUN or LAP)
//   state                 : IDLE=00, RUN=01, PAUSE=10, LAP=11
interface stopwatch_ctrl_if;
    logic       go_in;
    logic       lap_in;
    logic       clr_in;
    logic       tick_out;
    logic       clr_out;
    logic       lap_hold;
    logic       run;
    logic [1:0] state;

    modport master (
        output go_in, lap_in, clr_in,
        input  tick_out, clr_out, lap_hold, run, state
    );

    modport slave (
        input  go_in, lap_in, clr_in,
        output tick_out, clr_out, lap_hold, run, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller for the stopwatch. Turns debounced button
// levels into edge events, sequences IDLE/RUN/PAUSE/LAP and generates the
// count-enable tick, the clear pulse and the lap display freeze.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   sw  : stopwatch_ctrl_if.slave (button levels in, tick/clear/lap/run/state out)
// Parameters:
//   TICK_DVSR  : clk cycles per count tick (>= 2)
//   HOLD_TICKS : ticks clr_in must be held for a long-press clear (>= 1)
// Build option:
//   LONG_PRESS_CLR_EN : when defined, holding clr for HOLD_TICKS ticks while
//                       counting clears the stopwatch; otherwise clr is
//                       ignored in RUN and LAP.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DVSR  = 1_000_000,
    parameter int unsigned HOLD_TICKS = 100
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  sw
);

    localparam int unsigned PSC_W = $clog2(TICK_DVSR);
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(TICK_DVSR - 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_LAP   = 2'b11;

    // Elaboration-time parameter sanity checks
    if (TICK_DVSR < 2) begin : g_bad_dvsr
        $error("stopwatch_ctrl: TICK_DVSR must be >= 2");
    end
    if (HOLD_TICKS < 1) begin : g_bad_hold
        $error("stopwatch_ctrl: HOLD_TICKS must be >= 1");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_clr_pulse;
    logic             r_run;
    logic             r_lap_hold;
    logic             r_tick;
    logic             r_clr_out;
    logic [PSC_W-1:0] r_psc;
    logic             r_go_prev;
    logic             r_lap_prev;
    logic             r_clr_prev;
    logic             w_go_ev;
    logic             w_lap_ev;
    logic             w_clr_ev;
    logic             w_psc_wrap;
    logic             w_long_clr;

    // Rising-edge events; prev regs reset high so a held button is ignored
    assign w_go_ev  = sw.go_in  & ~r_go_prev;
    assign w_lap_ev = sw.lap_in & ~r_lap_prev;
    assign w_clr_ev = sw.clr_in & ~r_clr_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_go_prev  <= 1'b1;
            r_lap_prev <= 1'b1;
            r_clr_prev <= 1'b1;
        end else begin
            r_go_prev  <= sw.go_in;
            r_lap_prev <= sw.lap_in;
            r_clr_prev <= sw.clr_in;
        end
    end

`ifdef LONG_PRESS_CLR_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

    logic [HOLD_W-1:0] r_hold;

    // Long press fires once the counter has reached HOLD_TICKS with clr still held
    assign w_long_clr = r_run & sw.clr_in & (r_hold == HOLD_MAX);

    // Counts ticks while clr is held during counting; any release restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (!sw.clr_in || !r_run || w_long_clr) begin
            r_hold <= '0;
        end else if (r_tick) begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end
`else
    assign w_long_clr = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and clear request; events ignored in a state do not block
    // lower-priority events that are meaningful there
    always_comb begin
        w_state_nxt = r_state;
        w_clr_pulse = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_clr_ev) begin
                    w_clr_pulse = 1'b1;
                end else if (w_go_ev) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_go_ev) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_lap_ev) begin
                    w_state_nxt = ST_LAP;
                end
            end
            ST_LAP: begin
                if (w_go_ev) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_lap_ev) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (w_clr_ev) begin
                    w_clr_pulse = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_go_ev) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_long_clr) begin
            w_clr_pulse = 1'b1;
            w_state_nxt = ST_IDLE;
        end
    end

    // Registered Moore outputs, aligned with the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run      <= 1'b0;
            r_lap_hold <= 1'b0;
            r_clr_out  <= 1'b0;
        end else begin
            r_run      <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_LAP);
            r_lap_hold <= (w_state_nxt == ST_LAP);
            r_clr_out  <= w_clr_pulse;
        end
    end

    assign w_psc_wrap = (r_psc == PSC_MAX);

    // Prescaler: runs while counting, holds in PAUSE so phase survives a pause,
    // and sits at zero in IDLE so a fresh start gives a full first period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_psc  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= r_run & w_psc_wrap;
            if (r_run) begin
                r_psc <= w_psc_wrap ? '0 : r_psc + PSC_W'(1);
            end else if (r_state == ST_IDLE) begin
                r_psc <= '0;
            end
        end
    end

    assign sw.tick_out = r_tick;
    assign sw.clr_out  = r_clr_out;
    assign sw.lap_hold = r_lap_hold;
    assign sw.run      = r_run;
    assign sw.state    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DVSR=10, HOLD_TICKS=3.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl #(
        .TICK_DVSR (10),
        .HOLD_TICKS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw (sw)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Release for one cycle, then press; returns just after the event edge
    task automatic press(input int btn);
        case (btn)
            0: sw.go_in  = 1'b0;
            1: sw.lap_in = 1'b0;
            default: sw.clr_in = 1'b0;
        endcase
        step();
        case (btn)
            0: sw.go_in  = 1'b1;
            1: sw.lap_in = 1'b1;
            default: sw.clr_in = 1'b1;
        endcase
        step();
        case (btn)
            0: sw.go_in  = 1'b0;
            1: sw.lap_in = 1'b0;
            default: sw.clr_in = 1'b0;
        endcase
    endtask

    // Cycles until the next tick_out; -1 if none within the budget
    task automatic wait_tick(output int n);
        bit found;
        found = 0;
        n = 0;
        while (!found && n < 50) begin
            step();
            n++;
            if (sw.tick_out === 1'b1) found = 1;
        end
        if (!found) n = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        int ticks;
        int clrs;

        rst = 1'b1;
        sw.go_in  = 1'b1;
        sw.lap_in = 1'b0;
        sw.clr_in = 1'b0;
        repeat (3) step();
        chk("rst_state", 32'(sw.state), 0);
        chk("rst_run", 32'(sw.run), 0);
        chk("rst_lap_hold", 32'(sw.lap_hold), 0);
        chk("rst_tick", 32'(sw.tick_out), 0);
        chk("rst_clr_out", 32'(sw.clr_out), 0);

        // go held through reset release: no event
        rst = 1'b0;
        cnt = 0;
        repeat (4) begin
            step();
            if (sw.state !== 2'b00) cnt++;
        end
        chk("held_go_no_event", 32'(cnt), 0);

        press(0);
        chk("start_state", 32'(sw.state), 1);
        chk("start_run", 32'(sw.run), 1);
        wait_tick(n);
        chk("first_tick_latency", 32'(n), 10);

        // pause then clear from PAUSE
        press(0);
        chk("pause_state", 32'(sw.state), 2);
        press(2);
        chk("clr_pulse", 32'(sw.clr_out), 1);
        chk("clr_idle", 32'(sw.state), 0);
        step();
        chk("clr_one_cycle", 32'(sw.clr_out), 0);

        // 25 cycles of running, pause 40, resume: phase preserved
        press(0);
        ticks = 0;
        repeat (23) begin
            step();
            if (sw.tick_out === 1'b1) ticks++;
        end
        press(0);
        chk("run25_ticks", 32'(ticks), 2);
        chk("pause2_state", 32'(sw.state), 2);
        ticks = 0;
        cnt = 0;
        repeat (40) begin
            step();
            if (sw.tick_out === 1'b1) ticks++;
            if (sw.state !== 2'b10) cnt++;
        end
        chk("pause_no_tick", 32'(ticks), 0);
        chk("pause_stable", 32'(cnt), 0);
        press(0);
        chk("resume_state", 32'(sw.state), 1);
        wait_tick(n);
        chk("resume_phase", 32'(n), 5);

        // lap freeze, release, re-freeze then pause
        press(1);
        chk("lap_state", 32'(sw.state), 3);
        chk("lap_hold_on", 32'(sw.lap_hold), 1);
        chk("lap_run", 32'(sw.run), 1);
        wait_tick(n);
        chk("lap_tick_continues", 32'(n), 8);
        press(1);
        chk("unlap_state", 32'(sw.state), 1);
        chk("unlap_hold", 32'(sw.lap_hold), 0);
        press(1);
        chk("relap_state", 32'(sw.state), 3);
        press(0);
        chk("lap_go_state", 32'(sw.state), 2);
        chk("lap_go_hold", 32'(sw.lap_hold), 0);
        chk("lap_go_run", 32'(sw.run), 0);

        // PAUSE: clr and go together, clr wins
        step();
        sw.go_in  = 1'b1;
        sw.clr_in = 1'b1;
        step();
        sw.go_in  = 1'b0;
        sw.clr_in = 1'b0;
        chk("pri_clr_out", 32'(sw.clr_out), 1);
        chk("pri_state", 32'(sw.state), 0);
        chk("pri_run", 32'(sw.run), 0);
        step();
        chk("pri_clr_one", 32'(sw.clr_out), 0);

        // hold clr while running
        press(0);
        chk("hold_start", 32'(sw.state), 1);
        sw.clr_in = 1'b1;
        ticks = 0;
        clrs = 0;
        cnt = 0;
        repeat (35) begin
            step();
            if (sw.clr_out === 1'b1) clrs++;
            if (sw.tick_out === 1'b1 && clrs == 0) ticks++;
            if (sw.state !== 2'b01) cnt++;
        end
        sw.clr_in = 1'b0;
`ifdef LONG_PRESS_CLR_EN
        chk("long_clr_pulses", 32'(clrs), 1);
        chk("long_clr_ticks", 32'(ticks), 3);
        chk("long_clr_state", 32'(sw.state), 0);
        press(0);
`else
        chk("hold_no_clr", 32'(clrs), 0);
        chk("hold_state", 32'(cnt), 0);
        chk("hold_ticks", 32'(ticks), 3);
`endif

        // reset mid-LAP
        press(1);
        chk("pre_rst_lap", 32'(sw.state), 3);
        rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(sw.state), 0);
        chk("async_rst_hold", 32'(sw.lap_hold), 0);
        cnt = 0;
        repeat (2) begin
            step();
            if (sw.clr_out !== 1'b0 || sw.run !== 1'b0 || sw.tick_out !== 1'b0) cnt++;
        end
        rst = 1'b0;
        chk("rst_outputs_quiet", 32'(cnt), 0);
        chk("rst_run_off", 32'(sw.run), 0);
        press(0);
        chk("post_rst_start", 32'(sw.state), 1);
        wait_tick(n);
        chk("post_rst_first_tick", 32'(n), 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
